// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory controller.
// IO_DONE only exists when SLC3_MEM_IO_MAP_EN is defined.
package slc3_mem_pkg;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;
    localparam int          WAIT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
`ifdef SLC3_MEM_IO_MAP_EN
        ,
        IO_DONE
`endif
    } mem_state_t;

endpackage

// File: rtl/slc3_mem_ctrl_if.sv
// External async-SRAM bus seen by slc3_mem_ctrl; the controller is the master,
// the SRAM (or its model) is the slave. DQ is split into in/out/oe for a top-level tristate.
interface slc3_mem_ctrl_if;

    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        output SRAM_ADDR,
        output SRAM_DQ_out,
        output SRAM_DQ_oe,
        output SRAM_CE_N,
        output SRAM_OE_N,
        output SRAM_WE_N,
        output SRAM_UB_N,
        output SRAM_LB_N,
        input  SRAM_DQ_in
    );

    modport slave (
        input  SRAM_ADDR,
        input  SRAM_DQ_out,
        input  SRAM_DQ_oe,
        input  SRAM_CE_N,
        input  SRAM_OE_N,
        input  SRAM_WE_N,
        input  SRAM_UB_N,
        input  SRAM_LB_N,
        output SRAM_DQ_in
    );

endinterface

// File: rtl/slc3_mem_ctrl_sync2.sv
// sync2: parameterized-width two-flop synchronizer for asynchronous board inputs.
// Only built with SLC3_MEM_IO_MAP_EN, the sole configuration that instantiates it.
`ifdef SLC3_MEM_IO_MAP_EN
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: turns the SLC-3 sequencer's active-low memory strobes into timed async-SRAM cycles.
// Define SLC3_MEM_IO_MAP_EN to map address 0xFFFF onto Switches (read) and Hex_out (write).
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Mem_CE,
    input  logic            Mem_OE,
    input  logic            Mem_WE,
    input  logic [15:0]     MAR,
    input  logic [15:0]     MDR_out,
    input  logic [15:0]     Switches,
    output logic [15:0]     Data_to_CPU,
    output logic            mem_ready,
    output logic [15:0]     Hex_out,
    slc3_mem_ctrl_if.master sram
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_STATES[WAIT_W-1:0];

    mem_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              is_write, is_write_nxt;
    logic              req_rd, req_wr;
    logic              strobe_released;
    logic              latch_req, capture_rd;

    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        ce_n_q, oe_n_q, we_n_q, dq_oe_q, ready_q;
    logic        ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt, ready_nxt;

    // WE has priority: a request with both strobes low is a write.
    assign req_wr = ~Mem_CE & ~Mem_WE;
    assign req_rd = ~Mem_CE & Mem_WE & ~Mem_OE;
    assign strobe_released = is_write ? Mem_WE : Mem_OE;

`ifdef SLC3_MEM_IO_MAP_EN
    logic        io_hit, io_rd, io_wr;
    logic [15:0] switches_sync;
    logic [15:0] hex_q;

    assign io_hit = (MAR == IO_ADDR);
    assign io_rd  = (state == IDLE) & io_hit & req_rd;
    assign io_wr  = (state == IDLE) & io_hit & req_wr;

    sync2 #(.WIDTH(16)) u_switch_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (Switches),
        .q     (switches_sync)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else if (io_wr) begin
            hex_q <= MDR_out;
        end
    end

    assign Hex_out = hex_q;
`else
    logic switches_unused;

    assign switches_unused = ^Switches;
    assign Hex_out         = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            is_write <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            is_write <= is_write_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        is_write_nxt = is_write;
        latch_req    = 1'b0;
        capture_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (req_wr || req_rd) begin
                    is_write_nxt = req_wr;
`ifdef SLC3_MEM_IO_MAP_EN
                    if (io_hit) begin
                        state_nxt = IO_DONE;
                    end else
`endif
                    begin
                        latch_req    = 1'b1;
                        wait_cnt_nxt = WAIT_LOAD;
                        state_nxt    = req_wr ? WR_WAIT : RD_WAIT;
                    end
                end
            end
            // A strobe released mid-access abandons it with no ready pulse.
            RD_WAIT: begin
                if (strobe_released) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    capture_rd = 1'b1;
                    state_nxt  = RD_DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            WR_WAIT: begin
                if (strobe_released) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    state_nxt = WR_DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            RD_DONE: begin
                if (strobe_released) state_nxt = IDLE;
            end
            WR_DONE: begin
                if (strobe_released) state_nxt = IDLE;
            end
`ifdef SLC3_MEM_IO_MAP_EN
            IO_DONE: begin
                if (strobe_released) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Pin values are derived from the next state so every SRAM pin comes straight off a flop.
        ce_n_nxt  = !((state_nxt == RD_WAIT) || (state_nxt == WR_WAIT));
        oe_n_nxt  = (state_nxt != RD_WAIT);
        we_n_nxt  = (state_nxt != WR_WAIT);
        dq_oe_nxt = (state_nxt == WR_WAIT) || (state_nxt == WR_DONE);
        ready_nxt = (state_nxt == RD_DONE) || (state_nxt == WR_DONE)
`ifdef SLC3_MEM_IO_MAP_EN
                    || (state_nxt == IO_DONE)
`endif
                    ;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ce_n_q  <= ce_n_nxt;
            oe_n_q  <= oe_n_nxt;
            we_n_q  <= we_n_nxt;
            dq_oe_q <= dq_oe_nxt;
            ready_q <= ready_nxt;
            if (latch_req) begin
                addr_q  <= {4'h0, MAR};
                wdata_q <= MDR_out;
            end
            if (capture_rd) begin
                rdata_q <= sram.SRAM_DQ_in;
            end
`ifdef SLC3_MEM_IO_MAP_EN
            if (io_rd) begin
                rdata_q <= switches_sync;
            end
`endif
        end
    end

    assign sram.SRAM_ADDR   = addr_q;
    assign sram.SRAM_DQ_out = wdata_q;
    assign sram.SRAM_DQ_oe  = dq_oe_q;
    assign sram.SRAM_CE_N   = ce_n_q;
    assign sram.SRAM_OE_N   = oe_n_q;
    assign sram.SRAM_WE_N   = we_n_q;
    assign sram.SRAM_UB_N   = ce_n_q;
    assign sram.SRAM_LB_N   = ce_n_q;

    assign Data_to_CPU = rdata_q;
    assign mem_ready   = ready_q;

endmodule
